// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle ARM controller.
// The optional MUL decode is enabled with the MC_CTRL_MUL_EN macro.
package mc_ctrl_pkg;

   localparam int STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMRD    = 4'd3,
      MEMWB    = 4'd4,
      MEMWR    = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9
   } state_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_ORR = 3'b011;
   localparam logic [2:0] ALU_MUL = 3'b100;

   localparam logic [1:0] SRCB_WD  = 2'd0;
   localparam logic [1:0] SRCB_IMM = 2'd1;
   localparam logic [1:0] SRCB_4   = 2'd2;

   localparam logic [1:0] RES_ALUOUT = 2'd0;
   localparam logic [1:0] RES_DATA   = 2'd1;
   localparam logic [1:0] RES_ALURES = 2'd2;

   localparam logic [1:0] IMM_DP  = 2'b00;
   localparam logic [1:0] IMM_MEM = 2'b01;
   localparam logic [1:0] IMM_BR  = 2'b10;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE;

   // hi = Instr[27:22], lo = Instr[7:4]
   function automatic logic is_mul_pat(logic [5:0] hi, logic [3:0] lo);
      return (hi == 6'd0) && (lo == 4'b1001);
   endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle: instruction/flags in, every control line out.
interface mc_controller_if;
   import mc_ctrl_pkg::*;

   logic [31:0]        Instr;
   logic [3:0]         ALUFlags;
   logic               PCWrite;
   logic               MemWrite;
   logic               RegWrite;
   logic               IRWrite;
   logic               AdrSrc;
   logic [1:0]         RegSrc;
   logic               ALUSrcA;
   logic [1:0]         ALUSrcB;
   logic [1:0]         ResultSrc;
   logic [1:0]         ImmSrc;
   logic [2:0]         ALUControl;
   logic               opMul;
   logic [STATE_W-1:0] State;

   modport master (
      input  Instr, ALUFlags,
      output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
             ALUSrcB, ResultSrc, ImmSrc, ALUControl, opMul, State
   );

   modport slave (
      output Instr, ALUFlags,
      input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
             ALUSrcB, ResultSrc, ImmSrc, ALUControl, opMul, State
   );

endinterface

// File: rtl/mc_cond_unit.sv
// NZCV flags register and ARM condition-code evaluation.
module mc_cond_unit
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond_i,
   input  logic [3:0] alu_flags_i,
   input  logic       exec_i,
   input  logic       we_nz_i,
   input  logic       we_cv_i,
   output logic       cond_ex_o,
   output logic       cond_ex_wb_o
);

   logic [3:0] flags_q, flags_d;
   logic       n, z, c, v;
   logic       cond_wb_q;

   assign {n, z, c, v} = flags_q;

   always_comb begin
      flags_d = flags_q;
      if (we_nz_i) flags_d[3:2] = alu_flags_i[3:2];
      if (we_cv_i) flags_d[1:0] = alu_flags_i[1:0];
   end

   // ALUWB must see the verdict taken in EXECUTE, not the flags that instruction just wrote
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q   <= 4'b0000;
         cond_wb_q <= 1'b0;
      end else begin
         flags_q <= flags_d;
         if (exec_i) cond_wb_q <= cond_ex_o;
      end
   end

   always_comb begin
      case (cond_i)
         COND_EQ: cond_ex_o = z;
         COND_NE: cond_ex_o = ~z;
         COND_CS: cond_ex_o = c;
         COND_CC: cond_ex_o = ~c;
         COND_MI: cond_ex_o = n;
         COND_PL: cond_ex_o = ~n;
         COND_VS: cond_ex_o = v;
         COND_VC: cond_ex_o = ~v;
         COND_HI: cond_ex_o = c & ~z;
         COND_LS: cond_ex_o = ~c | z;
         COND_GE: cond_ex_o = (n == v);
         COND_LT: cond_ex_o = (n != v);
         COND_GT: cond_ex_o = ~z & (n == v);
         COND_LE: cond_ex_o = z | (n != v);
         COND_AL: cond_ex_o = 1'b1;
         default: cond_ex_o = 1'b0;
      endcase
   end

   assign cond_ex_wb_o = cond_wb_q;

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle ARM control unit: FSM, instruction decode and control-line generation.
// Optional MUL support is compiled in when MC_CTRL_MUL_EN is defined.
module mc_controller
   import mc_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   mc_controller_if.master ctrl
);

   state_t      state_q, state_d;
   logic [31:0] instr;
   logic [1:0]  op;
   logic [3:0]  cmd, rd;
   logic        i_bit, s_bit, l_bit, u_bit, mul_pat, is_mul;
   logic [2:0]  dp_alu;
   logic        dp_known, dp_cv, dp_nowrite;
   logic        cond_ex, cond_ex_wb, in_exec, flag_upd;
   logic        irw, pcw, memw, regw, adr, srca;
   logic [1:0]  srcb, res;
   logic [2:0]  alu;
   logic        unused_bits;

   assign instr       = ctrl.Instr;
   assign op          = instr[27:26];
   assign i_bit       = instr[25];
   assign cmd         = instr[24:21];
   assign u_bit       = instr[23];
   assign s_bit       = instr[20];
   assign l_bit       = instr[20];
   assign mul_pat     = is_mul_pat(instr[27:22], instr[7:4]);
   assign unused_bits = ^{instr[11:8], instr[3:0]};

`ifdef MC_CTRL_MUL_EN
   assign is_mul = mul_pat;
`else
   assign is_mul = 1'b0;
`endif

   // MUL keeps its destination in [19:16]
   assign rd = is_mul ? instr[19:16] : instr[15:12];

   always_comb begin
      dp_alu     = ALU_ADD;
      dp_known   = 1'b1;
      dp_cv      = 1'b0;
      dp_nowrite = 1'b0;
      if (is_mul) dp_alu = ALU_MUL;
      else begin
         case (cmd)
            CMD_ADD: begin dp_alu = ALU_ADD; dp_cv = 1'b1; end
            CMD_SUB: begin dp_alu = ALU_SUB; dp_cv = 1'b1; end
            CMD_AND: dp_alu = ALU_AND;
            CMD_ORR: dp_alu = ALU_ORR;
            CMD_CMP: begin dp_alu = ALU_SUB; dp_cv = 1'b1; dp_nowrite = 1'b1; end
            default: dp_known = 1'b0;
         endcase
      end
   end

   assign in_exec  = (state_q == EXECUTER) || (state_q == EXECUTEI);
   assign flag_upd = in_exec & s_bit & cond_ex & dp_known & ~reset;

   mc_cond_unit u_cond (
      .clk          (clk),
      .reset        (reset),
      .cond_i       (instr[31:28]),
      .alu_flags_i  (ctrl.ALUFlags),
      .exec_i       (in_exec),
      .we_nz_i      (flag_upd),
      .we_cv_i      (flag_upd & dp_cv),
      .cond_ex_o    (cond_ex),
      .cond_ex_wb_o (cond_ex_wb)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:  state_d = DECODE;
         DECODE: begin
            case (op)
               2'b01: state_d = MEMADR;
               2'b10: state_d = BRANCH;
               2'b00: begin
                  if (mul_pat && !is_mul) state_d = FETCH;
                  else if (!i_bit)        state_d = EXECUTER;
                  else                    state_d = EXECUTEI;
               end
               default: state_d = FETCH;
            endcase
         end
         MEMADR:   state_d = l_bit ? MEMRD : MEMWR;
         MEMRD:    state_d = MEMWB;
         EXECUTER: state_d = ALUWB;
         EXECUTEI: state_d = ALUWB;
         default:  state_d = FETCH;
      endcase
   end

   always_comb begin
      irw  = 1'b0;
      pcw  = 1'b0;
      memw = 1'b0;
      regw = 1'b0;
      adr  = 1'b0;
      srca = 1'b0;
      srcb = SRCB_WD;
      res  = RES_ALUOUT;
      alu  = ALU_ADD;
      case (state_q)
         FETCH:    begin irw = 1'b1; pcw = 1'b1; srca = 1'b1; srcb = SRCB_4; res = RES_ALURES; end
         DECODE:   begin srca = 1'b1; srcb = SRCB_4; res = RES_ALURES; end
         MEMADR:   begin srcb = SRCB_IMM; alu = u_bit ? ALU_ADD : ALU_SUB; end
         MEMRD:    adr = 1'b1;
         MEMWR:    begin adr = 1'b1; memw = cond_ex; end
         MEMWB:    begin res = RES_DATA; regw = cond_ex; pcw = cond_ex & (rd == 4'd15); end
         EXECUTER: alu = dp_alu;
         EXECUTEI: begin srcb = SRCB_IMM; alu = dp_alu; end
         ALUWB: begin
            regw = cond_ex_wb & dp_known & ~dp_nowrite;
            pcw  = cond_ex_wb & dp_known & ~dp_nowrite & (rd == 4'd15);
         end
         BRANCH:   begin srcb = SRCB_IMM; res = RES_ALURES; pcw = cond_ex; end
         default:  ;
      endcase
   end

   // reset blocks every architectural write in the cycle it is seen
   assign ctrl.PCWrite    = pcw  & ~reset;
   assign ctrl.MemWrite   = memw & ~reset;
   assign ctrl.RegWrite   = regw & ~reset;
   assign ctrl.IRWrite    = irw;
   assign ctrl.AdrSrc     = adr;
   assign ctrl.RegSrc     = {op == IMM_MEM, op == IMM_BR};
   assign ctrl.ALUSrcA    = srca;
   assign ctrl.ALUSrcB    = srcb;
   assign ctrl.ResultSrc  = res;
   assign ctrl.ImmSrc     = op;
   assign ctrl.ALUControl = alu;
   assign ctrl.opMul      = is_mul;
   assign ctrl.State      = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: directed cases then randomized instructions.
module tb_mc_controller;
   import mc_ctrl_pkg::*;

`ifdef MC_CTRL_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   localparam int K_NOP = 0, K_DPR = 1, K_DPI = 2, K_MUL = 3, K_LDR = 4, K_STR = 5, K_BR = 6;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, memw, regw, irw, adr;
      logic [1:0] regsrc;
      logic       srca;
      logic [1:0] srcb, res, imm;
      logic [2:0] alu;
      logic       opmul;
   } obs_t;

   typedef struct {
      obs_t        v;
      logic [31:0] ins;
   } sb_t;

   typedef struct packed {
      logic [2:0] alu;
      logic       known, cv, wr;
   } dp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mc_controller_if bus();
   mc_controller dut (.clk(clk), .reset(reset), .ctrl(bus));

   sb_t        sbq[$];
   int         total = 0, passed = 0;
   logic [3:0] mflags;

   function automatic logic cond_ok(logic [3:0] c, logic [3:0] f);
      logic n, z, cc, v, b;
      {n, z, cc, v} = f;
      case (c[3:1])
         3'd0:    b = z;
         3'd1:    b = cc;
         3'd2:    b = n;
         3'd3:    b = v;
         3'd4:    b = cc & ~z;
         3'd5:    b = (n == v);
         3'd6:    b = ~z & (n == v);
         default: b = 1'b1;
      endcase
      if (c == 4'hF) return 1'b0;
      if (c == 4'hE) return 1'b1;
      return b ^ c[0];
   endfunction

   function automatic int kind_of(logic [31:0] ins);
      logic mp;
      mp = (ins[27:22] == 6'd0) && (ins[7:4] == 4'b1001);
      case (ins[27:26])
         2'b01:   return ins[20] ? K_LDR : K_STR;
         2'b10:   return K_BR;
         2'b00:   if (mp) return MUL_EN ? K_MUL : K_NOP;
                  else    return ins[25] ? K_DPI : K_DPR;
         default: return K_NOP;
      endcase
   endfunction

   function automatic dp_t dp_of(logic [31:0] ins, int k);
      if (k == K_MUL) return '{ALU_MUL, 1'b1, 1'b0, 1'b1};
      case (ins[24:21])
         4'd4:    return '{ALU_ADD, 1'b1, 1'b1, 1'b1};
         4'd2:    return '{ALU_SUB, 1'b1, 1'b1, 1'b1};
         4'd0:    return '{ALU_AND, 1'b1, 1'b0, 1'b1};
         4'd12:   return '{ALU_ORR, 1'b1, 1'b0, 1'b1};
         4'd10:   return '{ALU_SUB, 1'b1, 1'b1, 1'b0};
         default: return '{ALU_ADD, 1'b0, 1'b0, 1'b0};
      endcase
   endfunction

   function automatic obs_t exp_obs(state_t s, logic [31:0] ins, logic ce, logic rst);
      obs_t       o;
      int         k;
      dp_t        d;
      logic [3:0] rd;
      k = kind_of(ins);
      d = dp_of(ins, k);
      rd = (k == K_MUL) ? ins[19:16] : ins[15:12];
      o = '0;
      o.st     = s;
      o.imm    = ins[27:26];
      o.regsrc = {ins[27:26] == 2'b01, ins[27:26] == 2'b10};
      o.opmul  = (k == K_MUL);
      o.alu    = ALU_ADD;
      case (s)
         FETCH:    begin o.irw = 1; o.pcw = 1; o.srca = 1; o.srcb = 2; o.res = 2; end
         DECODE:   begin o.srca = 1; o.srcb = 2; o.res = 2; end
         MEMADR:   begin o.srcb = 1; o.alu = ins[23] ? ALU_ADD : ALU_SUB; end
         MEMRD:    o.adr = 1;
         MEMWR:    begin o.adr = 1; o.memw = ce; end
         MEMWB:    begin o.res = 1; o.regw = ce; o.pcw = ce && rd == 4'd15; end
         EXECUTER: o.alu = d.alu;
         EXECUTEI: begin o.srcb = 1; o.alu = d.alu; end
         ALUWB:    begin o.regw = ce && d.known && d.wr; o.pcw = o.regw && rd == 4'd15; end
         BRANCH:   begin o.srcb = 1; o.res = 2; o.pcw = ce; end
         default:  ;
      endcase
      if (rst) begin o.pcw = 0; o.memw = 0; o.regw = 0; end
      return o;
   endfunction

   // Drive one instruction; reset is raised during path step rst_at (-1: never).
   task automatic run(input logic [31:0] ins, input int rst_at,
                      input bit xforce, input logic [3:0] xfl);
      state_t     path[$];
      int         k;
      logic       ce, rst;
      logic [3:0] fl;
      dp_t        d;
      k = kind_of(ins);
      d = dp_of(ins, k);
      path = '{FETCH, DECODE};
      case (k)
         K_DPR, K_MUL: path = '{FETCH, DECODE, EXECUTER, ALUWB};
         K_DPI:        path = '{FETCH, DECODE, EXECUTEI, ALUWB};
         K_LDR:        path = '{FETCH, DECODE, MEMADR, MEMRD, MEMWB};
         K_STR:        path = '{FETCH, DECODE, MEMADR, MEMWR};
         K_BR:         path = '{FETCH, DECODE, BRANCH};
         default:      ;
      endcase
      ce = cond_ok(ins[31:28], mflags);
      bus.Instr = ins;
      for (int i = 0; i < path.size(); i++) begin
         rst   = (i == rst_at);
         reset = rst;
         fl    = 4'($urandom);
         if (xforce && (path[i] == EXECUTER || path[i] == EXECUTEI)) fl = xfl;
         bus.ALUFlags = fl;
         sbq.push_back('{exp_obs(path[i], ins, ce, rst), ins});
         @(posedge clk); #1;
         if (rst) begin
            mflags = 4'b0000;
            reset  = 1'b0;
            break;
         end
         if ((path[i] == EXECUTER || path[i] == EXECUTEI) && ins[20] && ce && d.known) begin
            mflags[3:2] = fl[3:2];
            if (d.cv) mflags[1:0] = fl[1:0];
         end
      end
   endtask

   initial begin : monitor
      sb_t  e;
      obs_t a;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            a = '{bus.State, bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite, bus.AdrSrc,
                  bus.RegSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc,
                  bus.ALUControl, bus.opMul};
            total++;
            if (a === e.v) passed++;
            else $display("FAIL ctl ins=%h state got=%0d want=%0d vec got=%h want=%h",
                          e.ins, a.st, e.v.st, a, e.v);
         end
      end
   end

   initial begin : stim
      logic [31:0] ins;
      logic [3:0]  cmds [6];
      int          ra;
      cmds = '{4'd0, 4'd2, 4'd4, 4'd12, 4'd10, 4'd7};
      mflags       = 4'b0000;
      reset        = 1'b1;
      bus.Instr    = 32'd0;
      bus.ALUFlags = 4'd0;
      @(posedge clk); #1;
      sbq.push_back('{exp_obs(FETCH, 32'd0, 1'b0, 1'b1), 32'd0});
      @(posedge clk); #1;
      reset = 1'b0;

      run(32'hE0821003, -1, 0, 4'h0);      // ADD R1,R2,R3
      run(32'hE2500001, -1, 1, 4'b0100);   // SUBS -> Z=1
      run(32'h0A000002, -1, 0, 4'h0);      // BEQ taken
      run(32'hE2500001, -1, 1, 4'b0000);   // SUBS -> Z=0
      run(32'h0A000002, -1, 0, 4'h0);      // BEQ not taken
      run(32'hE5921004, -1, 0, 4'h0);      // LDR
      run(32'hE5821004, -1, 0, 4'h0);      // STR
      run(32'hE0000291, -1, 0, 4'h0);      // MUL
      run(32'hE0100291, -1, 1, 4'b1100);   // MULS
      run(32'h40821003, -1, 0, 4'h0);      // ADDMI
      run(32'hE5821004, 3, 0, 4'h0);       // STR, reset in MEMWR
      run(32'hE3500000, -1, 1, 4'b0110);   // CMP
      run(32'hE082F003, -1, 0, 4'h0);      // ADD PC,...
      run(32'hE592F004, -1, 0, 4'h0);      // LDR PC
      run(32'hE0E21003, -1, 0, 4'h0);      // unknown cmd
      run(32'hF0821003, -1, 0, 4'h0);      // cond NV
      run(32'hEC000000, -1, 0, 4'h0);      // op 11

      for (int n = 0; n < 400; n++) begin
         ins = $urandom;
         if ($urandom_range(0, 2) != 0) ins[31:28] = 4'hE;
         if (ins[27:26] == 2'b00) ins[24:21] = cmds[$urandom_range(0, 5)];
         if ($urandom_range(0, 9) == 0) begin
            ins[27:22] = 6'd0;
            ins[7:4]   = 4'b1001;
         end
         ra = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
         run(ins, ra, 0, 4'h0);
      end

      @(negedge clk); #1;
      total++;
      if (sbq.size() == 0) passed++;
      else $display("FAIL drain pending got=%0d want=0", sbq.size());
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
